riscv_uart_mmio: RTL and testbench



---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/riscv_sync_fifo.sv | 66 ++++++
 rtl/riscv_uart_mmio.sv | 218 +++++++++++++++++++++
 tb/tb_riscv_uart_mmio.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the hart-side peripherals.
//   - data-memory bus op encodings
//   - UART register word offsets (bus_addr[3:2]) and STATUS bit positions
//   - UART transmit FSM state type
//   - divisor clamp helper (a bit period shorter than 2 clocks is not allowed)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package riscv_pkg;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;
    localparam logic [1:0] UART_RSVD   = 2'd3;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// ---------------------------------------------------------------------------
// riscv_sync_fifo
// Single-clock FIFO with first-word fall-through read data.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (empties the FIFO)
//   push   in   write wdata at the clock edge (ignored when full)
//   wdata  in   write data
//   pop    in   advance the read pointer at the clock edge (ignored when empty)
//   rdata  out  head entry, valid whenever empty is low
//   full   out  no free entry
//   empty  out  no stored entry
// DEPTH must be a power of two and at least 2. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module riscv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: resetting the pointers already discards it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/riscv_uart_mmio.sv
// ---------------------------------------------------------------------------
// riscv_uart_mmio
// Transmit-only 8N1 UART mapped into a 16-byte window on the hart's
// data-memory port.
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   bus_addr      in   byte address; [31:4] selects the window, [3:2] the register
//   bus_op        in   00 idle, 01 load, 10 store, 11 treated as idle
//   bus_wdata     in   store data
//   bus_rdata     out  load data, combinational, 0 when bus_sel is low
//   bus_sel       out  combinational window hit for a load or store
//   uart_tx       out  serial line, registered, idles high
//   tx_empty_irq  out  registered: FIFO empty and transmitter idle
//
// Registers (word offset):
//   0x0 TXDATA   store pushes wdata[7:0]; load reads 0
//   0x4 STATUS   {28'b0, overflow, busy, fifo_empty, fifo_full}; store bit3 clears overflow
//   0x8 DIVISOR  clk cycles per bit, writes below 2 are clamped to 2
//   0xC reserved
//
// Transmit FSM:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   TX_IDLE  | line high; pops the FIFO head as soon as one is present
//   TX_START | start bit (line low) for one bit period
//   TX_DATA  | eight data bits, LSB first, one bit period each
//   TX_STOP  | stop bit (line high) for one bit period, then back to idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module riscv_uart_mmio
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_addr,
    input  logic [1:0]  bus_op,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_sel,
    output logic        uart_tx,
    output logic        tx_empty_irq
);

    logic        in_window;
    logic [1:0]  reg_off;
    logic        reg_wr;
    logic        txdata_wr;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [15:0] div;
    logic        overflow;
    logic        busy;
    logic [3:0]  status;

    tx_state_t   state;
    logic [7:0]  shreg;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic        bit_tc;

    logic        unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    assign in_window = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign bus_sel   = in_window && ((bus_op == OP_LOAD) || (bus_op == OP_STORE));
    assign reg_off   = bus_addr[3:2];
    assign reg_wr    = bus_sel && (bus_op == OP_STORE);
    assign txdata_wr = reg_wr && (reg_off == UART_TXDATA);

    // fifo_full is registered state, so a store into a full FIFO is dropped
    // even when the transmitter pops on the same edge.
    assign fifo_push = txdata_wr && !fifo_full;
    assign fifo_pop  = (state == TX_IDLE) && !fifo_empty;

    assign busy = (state != TX_IDLE);

    always_comb begin
        status             = '0;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_BUSY]  = busy;
        status[STAT_OVF]   = overflow;
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_sel) begin
            case (reg_off)
                UART_STATUS: bus_rdata = {28'b0, status};
                UART_DIV:    bus_rdata = {16'b0, div};
                default:     bus_rdata = '0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (reg_wr && (reg_off == UART_DIV)) begin
                div <= clamp_div(bus_wdata[15:0]);
            end
            // Set and clear come from different offsets, so they never collide.
            if (txdata_wr && fifo_full) begin
                overflow <= 1'b1;
            end else if (reg_wr && (reg_off == UART_STATUS) && bus_wdata[STAT_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------------
    riscv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (bus_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------------------------------------------------------------
    // Transmit FSM. bit_cnt is a down-counter reloaded with div-1 at every
    // bit boundary, so a divisor change lands on the next bit, never the
    // one in flight.
    // ---------------------------------------------------------------------
    assign bit_tc = (bit_cnt == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    uart_tx <= 1'b1;
                    if (!fifo_empty) begin
                        shreg   <= fifo_rdata;
                        bit_cnt <= div - 16'd1;
                        uart_tx <= 1'b0;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_tc) begin
                        bit_cnt <= div - 16'd1;
                        bit_idx <= 3'd0;
                        uart_tx <= shreg[0];
                        state   <= TX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (bit_tc) begin
                        bit_cnt <= div - 16'd1;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= TX_STOP;
                        end else begin
                            // shreg[0] is on the line; the next bit is shreg[1].
                            shreg   <= {1'b0, shreg[7:1]};
                            uart_tx <= shreg[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (bit_tc) begin
                        state <= TX_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    state   <= TX_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_empty_irq <= 1'b1;
        end else begin
            tx_empty_irq <= fifo_empty && !busy;
        end
    end

endmodule

// File: tb/tb_riscv_uart_mmio.sv
`timescale 1ns/1ps

module tb_riscv_uart_mmio;
    import riscv_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bus_addr;
    logic [1:0]  bus_op;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_sel;
    logic        uart_tx;
    logic        tx_empty_irq;

    riscv_uart_mmio dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_addr     (bus_addr),
        .bus_op       (bus_op),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_sel      (bus_sel),
        .uart_tx      (uart_tx),
        .tx_empty_irq (tx_empty_irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0]       data;
        logic [9:0][15:0] lens;
    } frame_t;

    frame_t      exp_frames[$];
    logic [31:0] exp_rd[$];
    string       exp_rd_name[$];
    string       chk_name[$];
    logic [31:0] chk_act[$];
    logic [31:0] chk_exp[$];

    // ------------------------------------------------------------------
    // Scoreboard side (only the monitor touches the counters)
    // ------------------------------------------------------------------
    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return d[k-1];
    endfunction

    bit     in_frame = 1'b0;
    bit     stray = 1'b0;
    int     fk;
    int     fcyc;
    logic   fbad;
    logic   fexp;
    frame_t cur;

    always @(negedge clk) begin
        while (chk_name.size() > 0)
            compare(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());

        if (rst_n && bus_sel && bus_op == OP_LOAD) begin
            if (exp_rd.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_load: got rdata 0x%08h required no load", bus_rdata);
            end else begin
                compare(exp_rd_name.pop_front(), bus_rdata, exp_rd.pop_front());
            end
        end

        if (!rst_n) begin
            in_frame = 1'b0;
            stray    = 1'b0;
            exp_frames.delete();
        end else begin
            if (stray && uart_tx) stray = 1'b0;
            if (!in_frame && !stray && uart_tx == 1'b0) begin
                if (exp_frames.size() == 0) begin
                    tests++;
                    fails++;
                    stray = 1'b1;
                    $display("FAIL unexpected_frame: got uart_tx 0 required 1 (no frame queued)");
                end else begin
                    cur      = exp_frames.pop_front();
                    in_frame = 1'b1;
                    fk       = 0;
                    fcyc     = 0;
                    fbad     = 1'b0;
                end
            end
            if (in_frame) begin
                fexp = frame_bit(cur.data, fk);
                if (uart_tx !== fexp) fbad = 1'b1;
                fcyc++;
                if (fcyc == int'(cur.lens[fk])) begin
                    tests++;
                    if (fbad) begin
                        fails++;
                        $display("FAIL frame_%02h_bit%0d: got %0b during the bit, required %0b for %0d cycles",
                                 cur.data, fk, ~fexp, fexp, fcyc);
                    end
                    fk++;
                    fcyc = 0;
                    fbad = 1'b0;
                    if (fk == 10) in_frame = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus side
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_name.push_back(name);
        chk_act.push_back(act);
        chk_exp.push_back(exp);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic [15:0] div);
        frame_t f;
        f.data = d;
        for (int k = 0; k < 10; k++) f.lens[k] = div;
        exp_frames.push_back(f);
    endtask

    task automatic bus_store(input logic [31:0] addr, input logic [31:0] data);
        bus_addr  = addr;
        bus_wdata = data;
        bus_op    = OP_STORE;
        @(posedge clk);
        #1;
        bus_op = OP_IDLE;
    endtask

    task automatic bus_load(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_rd.push_back(exp);
        exp_rd_name.push_back(name);
        bus_addr = addr;
        bus_op   = OP_LOAD;
        @(posedge clk);
        #1;
        bus_op = OP_IDLE;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        repeat (2) @(posedge clk);
        while (!(tx_empty_irq && exp_frames.size() == 0 && !in_frame) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, {31'b0, tx_empty_irq}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within 200 us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t f;
        int     lows;

        bus_addr  = '0;
        bus_op    = OP_IDLE;
        bus_wdata = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_irq", {31'b0, tx_empty_irq}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset state
        bus_load(BASE + 32'h4, 32'h2, "t1_status");
        bus_load(BASE + 32'h8, 32'd434, "t1_div");
        check("t1_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("t1_irq", {31'b0, tx_empty_irq}, 32'd1);

        // 2: one frame of 0xA5 at div 4, first low cycle after the next edge
        bus_store(BASE + 32'h8, 32'd4);
        push_frame(8'hA5, 16'd4);
        bus_store(BASE + 32'h0, 32'hA5);
        @(negedge clk);
        check("t2_tx_idle_before_pop", {31'b0, uart_tx}, 32'd1);
        @(negedge clk);
        check("t2_tx_first_low", {31'b0, uart_tx}, 32'd0);
        @(posedge clk);
        #1;
        bus_load(BASE + 32'h4, 32'h6, "t2_status_busy");
        wait_idle(200, "t2_idle");

        // 3: fill the FIFO behind a running frame, overflow, clear
        bus_store(BASE + 32'h8, 32'd2);
        push_frame(8'h11, 16'd2);
        bus_store(BASE + 32'h0, 32'h11);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++) begin
            push_frame(8'h40 + 8'(i), 16'd2);
            bus_store(BASE + 32'h0, 32'h40 + i);
        end
        bus_load(BASE + 32'h4, 32'h5, "t3_status_full");
        bus_store(BASE + 32'h0, 32'h49);
        bus_load(BASE + 32'h4, 32'hD, "t3_status_overflow");
        bus_store(BASE + 32'h4, 32'h8);
        bus_load(BASE + 32'h4, 32'h5, "t3_status_cleared");
        wait_idle(400, "t3_idle");
        bus_load(BASE + 32'h4, 32'h2, "t3_status_drained");

        // 4: clamp and mid-frame divisor change
        bus_store(BASE + 32'h8, 32'd0);
        bus_load(BASE + 32'h8, 32'd2, "t4_div_clamped");
        f.data = 8'h55;
        for (int k = 0; k < 10; k++) f.lens[k] = 16'd8;
        f.lens[0] = 16'd2;
        f.lens[1] = 16'd2;
        exp_frames.push_back(f);
        bus_store(BASE + 32'h0, 32'h55);
        repeat (3) @(posedge clk);
        #1;
        bus_store(BASE + 32'h8, 32'd8);
        bus_load(BASE + 32'h8, 32'd8, "t4_div_new");
        wait_idle(200, "t4_idle");

        // 5: window and offset decode
        bus_addr  = BASE + 32'h10;
        bus_wdata = 32'h77;
        bus_op    = OP_STORE;
        #1;
        check("t5_sel_outside_store", {31'b0, bus_sel}, 32'd0);
        check("t5_rdata_outside", bus_rdata, 32'd0);
        @(posedge clk);
        #1;
        bus_addr = BASE + 32'h4;
        bus_op   = 2'b11;
        #1;
        check("t5_sel_reserved_op", {31'b0, bus_sel}, 32'd0);
        check("t5_rdata_reserved_op", bus_rdata, 32'd0);
        @(posedge clk);
        #1;
        bus_op = OP_IDLE;
        repeat (4) @(posedge clk);
        #1;
        bus_load(BASE + 32'h4, 32'h2, "t5_no_push");
        bus_store(BASE + 32'hB, 32'd4);
        bus_load(BASE + 32'h8, 32'd4, "t5_div_low_bits_ignored");
        bus_store(BASE + 32'hC, 32'hFF);
        bus_load(BASE + 32'hC, 32'd0, "t5_reserved_load");
        bus_load(BASE + 32'h4, 32'h2, "t5_reserved_store_ignored");
        bus_load(BASE + 32'h0, 32'd0, "t5_txdata_load");
        push_frame(8'h5A, 16'd4);
        bus_store(BASE + 32'h3, 32'h5A);
        wait_idle(200, "t5_idle");

        // 6: reset in the middle of a data bit with 3 bytes queued
        push_frame(8'h00, 16'd4);
        bus_store(BASE + 32'h0, 32'h00);
        for (int i = 1; i <= 3; i++) begin
            push_frame(8'h80 + 8'(i), 16'd4);
            bus_store(BASE + 32'h0, 32'h80 + i);
        end
        repeat (6) @(posedge clk);
        #3;
        check("t6_tx_low_before_rst", {31'b0, uart_tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_tx_async_high", {31'b0, uart_tx}, 32'd1);
        check("t6_irq_async_high", {31'b0, tx_empty_irq}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_load(BASE + 32'h4, 32'h2, "t6_status_after_rst");
        bus_load(BASE + 32'h8, 32'd434, "t6_div_after_rst");
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        #1;
        check("t6_no_frames_after_rst", 32'(lows), 32'd0);

        check("frames_left", 32'(exp_frames.size()), 32'd0);
        check("loads_left", 32'(exp_rd.size()), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
